// File: rtl/spike_packetizer_pkg.sv
// rtl/spike_packetizer_pkg.sv - shared sizes, FSM encoding and bus-slicing helpers for the spike packetizer
package spike_packetizer_pkg;

  localparam int NEURONS  = 10;
  localparam int ADDR_W   = 12;
  localparam int MAX_CONN = 30;
  localparam int PTR_W    = 5;
  localparam int IDX_W    = $clog2(NEURONS);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    SEND = 2'd2
  } state_e;

  // LSB offsets of one field inside the flattened configuration buses
  function automatic int addr_lsb(input int i);
    return ADDR_W * i;
  endfunction

  function automatic int ptr_lsb(input int i);
    return PTR_W * (NEURONS - i);
  endfunction

  function automatic int conn_lsb(input int k);
    return ADDR_W * (MAX_CONN - 1 - k);
  endfunction

endpackage

// File: rtl/spike_priority_encoder.sv
// rtl/spike_priority_encoder.sv - lowest-set-index encoder with any-set flag
module spike_priority_encoder
  import spike_packetizer_pkg::*;
#(
  parameter int N = NEURONS,
  parameter int W = $clog2(N)
) (
  input  logic [N-1:0] pending,
  output logic [W-1:0] idx,
  output logic         any
);

  always_comb begin
    idx = '0;
    any = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (pending[i]) begin
        idx = W'(i);
        any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/spike_packetizer.sv
// rtl/spike_packetizer.sv - expands a captured spike vector through the CSR table into (origin, destination) packets
module spike_packetizer
  import spike_packetizer_pkg::*;
(
  input  logic                         CLK,
  input  logic                         RESET_N,
  input  logic                         init,
  input  logic [NEURONS*ADDR_W-1:0]    neuron_addresses_initialization,
  input  logic [(NEURONS+1)*PTR_W-1:0] connection_pointer_initialization,
  input  logic [MAX_CONN*ADDR_W-1:0]   downstream_connections_initialization,
  input  logic [NEURONS-1:0]           spike,
  input  logic                         spike_valid,
  input  logic                         pkt_ready,
  output logic                         pkt_valid,
  output logic [ADDR_W-1:0]            pkt_origin,
  output logic [ADDR_W-1:0]            pkt_destination,
  output logic                         busy,
  output logic                         done,
  output logic                         overrun
);

  state_e              state_q, state_d;
  logic [NEURONS-1:0]  pending_q, pending_d, spike_q, spike_d;
  logic                spike_valid_q, spike_valid_d;
  logic                done_q, done_d, overrun_q, overrun_d;
  logic [PTR_W-1:0]    cur_q, cur_d, end_q, end_d;
  logic [ADDR_W-1:0]   origin_q, origin_d, dest_q, dest_d;
  logic [ADDR_W-1:0]   addr_q [NEURONS];
  logic [ADDR_W-1:0]   addr_d [NEURONS];
  logic [PTR_W-1:0]    ptr_q  [NEURONS+1];
  logic [PTR_W-1:0]    ptr_d  [NEURONS+1];
  logic [ADDR_W-1:0]   conn_q [MAX_CONN];
  logic [ADDR_W-1:0]   conn_d [MAX_CONN];

  logic [IDX_W-1:0]    sel_idx;
  logic                sel_any;
  logic [PTR_W-1:0]    sel_cur, sel_nxt, sel_end, next_cur, conn_rd_idx;
  logic [ADDR_W-1:0]   conn_rd;
  logic                accept;

  spike_priority_encoder u_penc (
    .pending (pending_q),
    .idx     (sel_idx),
    .any     (sel_any)
  );

  assign sel_cur     = ptr_q[sel_idx];
  assign sel_nxt     = ptr_q[sel_idx + IDX_W'(1)];
  assign sel_end     = (sel_nxt > PTR_W'(MAX_CONN)) ? PTR_W'(MAX_CONN) : sel_nxt;
  assign next_cur    = cur_q + PTR_W'(1);
  assign conn_rd_idx = (state_q == SCAN) ? sel_cur : next_cur;
  assign conn_rd     = (conn_rd_idx < PTR_W'(MAX_CONN)) ? conn_q[conn_rd_idx] : '0;

  always_comb begin
    state_d       = state_q;
    pending_d     = pending_q;
    spike_d       = spike_q;
    spike_valid_d = 1'b0;
    overrun_d     = overrun_q;
    cur_d         = cur_q;
    end_d         = end_q;
    origin_d      = origin_q;
    dest_d        = dest_q;
    addr_d        = addr_q;
    ptr_d         = ptr_q;
    conn_d        = conn_q;

    // a vector is only taken when nothing is queued or in flight
    accept = spike_valid && (state_q == IDLE) && !spike_valid_q;
    if (accept) begin
      spike_valid_d = 1'b1;
      spike_d       = spike;
    end else if (spike_valid) begin
      overrun_d = 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (spike_valid_q) begin
          pending_d = spike_q;
          state_d   = SCAN;
        end
      end
      SCAN: begin
        if (!sel_any) begin
          state_d = IDLE;
        end else begin
          pending_d[sel_idx] = 1'b0;
          cur_d = sel_cur;
          end_d = sel_end;
          if (sel_cur < sel_end) begin
            state_d  = SEND;
            origin_d = addr_q[sel_idx];
            dest_d   = conn_rd;
          end
        end
      end
      SEND: begin
        if (pkt_ready) begin
          cur_d = next_cur;
          if (next_cur == end_q) state_d = SCAN;
          else                   dest_d  = conn_rd;
        end
      end
      default: state_d = IDLE;
    endcase

    if (init) begin
      for (int i = 0; i < NEURONS; i++)
        addr_d[i] = neuron_addresses_initialization[addr_lsb(i) +: ADDR_W];
      for (int i = 0; i <= NEURONS; i++)
        ptr_d[i] = connection_pointer_initialization[ptr_lsb(i) +: PTR_W];
      for (int k = 0; k < MAX_CONN; k++)
        conn_d[k] = downstream_connections_initialization[conn_lsb(k) +: ADDR_W];
      pending_d     = '0;
      overrun_d     = 1'b0;
      spike_valid_d = 1'b0;
      state_d       = IDLE;
    end

    done_d = (state_d == SCAN) && (pending_d == '0);
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q       <= IDLE;
      pending_q     <= '0;
      spike_q       <= '0;
      spike_valid_q <= 1'b0;
      done_q        <= 1'b0;
      overrun_q     <= 1'b0;
      cur_q         <= '0;
      end_q         <= '0;
      origin_q      <= '0;
      dest_q        <= '0;
      for (int i = 0; i < NEURONS; i++)  addr_q[i] <= '0;
      for (int i = 0; i <= NEURONS; i++) ptr_q[i]  <= '0;
      for (int k = 0; k < MAX_CONN; k++) conn_q[k] <= '0;
    end else begin
      state_q       <= state_d;
      pending_q     <= pending_d;
      spike_q       <= spike_d;
      spike_valid_q <= spike_valid_d;
      done_q        <= done_d;
      overrun_q     <= overrun_d;
      cur_q         <= cur_d;
      end_q         <= end_d;
      origin_q      <= origin_d;
      dest_q        <= dest_d;
      addr_q        <= addr_d;
      ptr_q         <= ptr_d;
      conn_q        <= conn_d;
    end
  end

  assign pkt_valid       = (state_q == SEND);
  assign busy            = (state_q != IDLE);
  assign pkt_origin      = origin_q;
  assign pkt_destination = dest_q;
  assign done            = done_q;
  assign overrun         = overrun_q;

endmodule

// File: doc/spike_packetizer.md
# spike_packetizer

Transmit-side spike encoder for a neuromorphic tile. Captures the per-timestep spike vector produced by the accelerator and expands it through the tile's CSR connectivity table (connection pointers plus downstream addresses) into a serial stream of (origin, destination) spike packets. The stream drives the NoC injection port over a valid/ready handshake. It is the sending counterpart of the spike_origin/spike_destination packets the accelerator consumes.

## Interface
- NEURONS, 10, neurons per tile
- ADDR_W, 12, neuron address width
- MAX_CONN, 30, downstream table depth
- PTR_W, 5, CSR pointer width
- CLK  in  1  clock, rising edge
- RESET_N  in  1  asynchronous active-low reset
- init  in  1  load configuration buses into internal registers
- neuron_addresses_initialization  in  NEURONS*ADDR_W  neuron i at [ADDR_W*i +: ADDR_W]
- connection_pointer_initialization  in  (NEURONS+1)*PTR_W  ptr[i] at [PTR_W*(NEURONS-i) +: PTR_W] (ptr[0] in MSBs)
- downstream_connections_initialization  in  MAX_CONN*ADDR_W  entry k at [ADDR_W*(MAX_CONN-1-k) +: ADDR_W] (entry 0 in MSBs)
- spike  in  NEURONS  spike vector from accelerator
- spike_valid  in  1  one-cycle strobe at end of timestep; spike is sampled on this edge
- pkt_ready  in  1  NoC accepts packet
- pkt_valid  out  1  packet present
- pkt_origin  out  ADDR_W  address of spiking neuron
- pkt_destination  out  ADDR_W  downstream neuron address
- busy  out  1  state != IDLE
- done  out  1  one-cycle pulse when a timestep's stream completes
- overrun  out  1  sticky: spike_valid arrived while busy

## Operation
- Reset: state IDLE; pending, config registers, pkt_origin, pkt_destination all zero; pkt_valid, busy, done, overrun 0.
- init (any state) loads all three configuration buses, clears pending and overrun, and forces IDLE. An in-flight packet is dropped. init has priority over spike_valid in the same cycle.
- States:
  - IDLE: on spike_valid, pending <= spike and go to SCAN. A zero vector still passes through SCAN and pulses done.
  - SCAN: if pending == 0, go to IDLE with done = 1 for one cycle. Otherwise select the lowest set index i, clear pending[i], and load cur = ptr[i], end = min(ptr[i+1], MAX_CONN). If cur >= end, stay in SCAN; the neuron has no connections and emits nothing. Otherwise go to SEND.
  - SEND: pkt_valid = 1, pkt_origin = neuron_addr[i], pkt_destination = entry[cur]. On pkt_valid && pkt_ready: cur++. If cur+1 == end, return to SCAN; otherwise stay in SEND.
- Packets are emitted in ascending neuron index, and in ascending table entry within a neuron.
- spike_valid while busy: the vector is discarded and overrun is set. The current stream is unaffected.
- No arithmetic beyond the PTR_W increment and compare. Pointers wider than the table are clamped via end.

## Timing
- Outputs are registered.
- spike_valid sampled at edge N: SCAN during cycle N+1; first pkt_valid asserted after edge N+2.
- Each neuron with no connections costs 1 SCAN cycle.
- Each neuron-to-neuron transition costs 1 bubble cycle (SEND -> SCAN -> SEND).
- Within one neuron, packets go out back-to-back, one per cycle, while pkt_ready is held high.
- While pkt_valid && !pkt_ready, pkt_origin and pkt_destination are held stable. pkt_valid never deasserts without a handshake, except on init or reset.
- done is asserted for exactly one cycle, the SCAN cycle that finds pending == 0. busy falls on the following edge.
- Reset asserted mid-stream: all outputs go to their reset values immediately (asynchronously).

## Structure
- Shared package/define file holds:
  - NEURONS, ADDR_W, MAX_CONN, PTR_W defaults
  - the state encoding: IDLE = 2'd0, SCAN = 2'd1, SEND = 2'd2
  - the bus-slicing index macros
- One natural sub-module: spike_priority_encoder. It is combinational; it takes pending and returns the lowest set index plus an any-set flag. It is reusable by the receiver-side arbiter.

## Test plan
Use the standard tile configuration: addresses 0..9, ptr = {0,3,5,8,10,12,14,15,17,18,19}, entries 0..18 = 3,5,7,4,6,4,5,6,8,9,8,9,8,9,9,8,9,0xFFB,0xFFC.
- spike = 10'b0000000001, pkt_ready = 1 -> packets (0,3), (0,5), (0,7) on consecutive cycles, then done one cycle later; first pkt_valid appears 2 edges after spike_valid.
- spike = 10'b1110000010 -> (1,4), (1,6), (7,8), (7,9), (8,0xFFB), (9,0xFFC) in that order; a 1-cycle bubble at each neuron change.
- spike = neuron 0, pkt_ready low for 5 cycles on the second packet -> (0,5) held stable for 5 cycles with no loss or duplication, then (0,7).
- ptr[3] = ptr[4] = 8 with spike = 10'b0000001000 -> no packets; done pulses 2 cycles after spike_valid.
- Second spike_valid during the neuron-0 stream -> overrun = 1 and remains set; stream completes unchanged; init clears overrun.
- RESET_N pulsed low mid-SEND -> pkt_valid, busy, done drop immediately; next spike_valid restarts from neuron index 0.
